// File: rtl/tap_pkg.sv
// Shared TAP definitions: state encoding, instruction opcodes and TDO source select.
// Imported by the TAP controller and by the test-data-register block.
package tap_pkg;

  typedef enum logic [3:0] {
    ST_TLR    = 4'hF,
    ST_RTI    = 4'hC,
    ST_SEL_DR = 4'h7,
    ST_CAP_DR = 4'h6,
    ST_SH_DR  = 4'h2,
    ST_EX1_DR = 4'h1,
    ST_PAU_DR = 4'h3,
    ST_EX2_DR = 4'h0,
    ST_UPD_DR = 4'h5,
    ST_SEL_IR = 4'h4,
    ST_CAP_IR = 4'hE,
    ST_SH_IR  = 4'hA,
    ST_EX1_IR = 4'h9,
    ST_PAU_IR = 4'hB,
    ST_EX2_IR = 4'h8,
    ST_UPD_IR = 4'hD
  } tap_state_e;

  localparam logic [3:0] BYPASS   = 4'hF;
  localparam logic [3:0] SAMPLE   = 4'h1;
  localparam logic [3:0] EXTEST   = 4'h2;
  localparam logic [3:0] INTEST   = 4'h3;
  localparam logic [3:0] RUNBIST  = 4'h4;
  localparam logic [3:0] CLAMP    = 4'h5;
  localparam logic [3:0] HIGHZ    = 4'h6;
  localparam logic [3:0] IDCODE   = 4'h7;
  localparam logic [3:0] USERCODE = 4'h8;

  localparam logic [3:0] IR_CAPTURE_DEFAULT = 4'b0001;

  // Which serial source drives TDO during a shift
  typedef enum logic [1:0] {
    SEL_INT  = 2'd0,
    SEL_ID   = 2'd1,
    SEL_USER = 2'd2,
    SEL_BSR  = 2'd3
  } tdo_sel_e;

endpackage

// File: rtl/tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine: state register plus TMS-driven next-state logic.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_e state
);

  tap_state_e r_state;
  tap_state_e w_next;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) r_state <= ST_TLR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = ST_TLR;
    case (r_state)
      ST_TLR:    w_next = TMS ? ST_TLR    : ST_RTI;
      ST_RTI:    w_next = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: w_next = TMS ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: w_next = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  w_next = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: w_next = TMS ? ST_UPD_DR : ST_PAU_DR;
      ST_PAU_DR: w_next = TMS ? ST_EX2_DR : ST_PAU_DR;
      ST_EX2_DR: w_next = TMS ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: w_next = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: w_next = TMS ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: w_next = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  w_next = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: w_next = TMS ? ST_UPD_IR : ST_PAU_IR;
      ST_PAU_IR: w_next = TMS ? ST_EX2_IR : ST_PAU_IR;
      ST_EX2_IR: w_next = TMS ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: w_next = TMS ? ST_SEL_DR : ST_RTI;
      default:   w_next = ST_TLR;
    endcase
  end

  assign state = r_state;

endmodule

// File: rtl/tap_ctrl.sv
// TAP controller: FSM, instruction/bypass registers, DR strobes and TDO mux.
// Defining TAP_STATE_OUT_EN adds the TAP_STATE debug port.
module tap_ctrl
  import tap_pkg::*;
#(
  parameter int                    IR_WIDTH         = 4,
  parameter logic [IR_WIDTH-1:0]   IR_RESET_VALUE   = IR_WIDTH'(IDCODE),
  parameter logic [IR_WIDTH-1:0]   IR_CAPTURE_VALUE = IR_WIDTH'(IR_CAPTURE_DEFAULT)
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                BSR_TDO,
  input  logic                ID_TDO,
  input  logic                USER_TDO,
  output logic                TLR,
  output logic                CAPTURE_DR,
  output logic                SHIFT_DR,
  output logic                UPDATE_DR,
  output logic                ENABLE,
  output logic [IR_WIDTH-1:0] LATCH_IR,
  output logic                TDO,
`ifdef TAP_STATE_OUT_EN
  output logic [3:0]          TAP_STATE,
`endif
  output logic                TDO_EN
);

  tap_state_e            w_state;
  logic                  w_sh_dr;
  logic                  w_sh_ir;
  logic                  w_tdo_int;
  tdo_sel_e              w_sel;
  logic [IR_WIDTH-1:0]   r_ir_sr;
  logic [IR_WIDTH-1:0]   r_latch_ir;
  logic                  r_bypass;
  logic                  r_tdo_q;
  logic                  r_tdo_en;
  tdo_sel_e              r_tdo_sel;

  tap_fsm u_fsm (
    .TCK   (TCK),
    .TRST  (TRST),
    .TMS   (TMS),
    .state (w_state)
  );

  assign w_sh_dr    = (w_state == ST_SH_DR);
  assign w_sh_ir    = (w_state == ST_SH_IR);
  assign TLR        = (w_state == ST_TLR);
  assign CAPTURE_DR = (w_state == ST_CAP_DR);
  assign SHIFT_DR   = w_sh_dr;
  assign UPDATE_DR  = (w_state == ST_UPD_DR);
  assign ENABLE     = (w_state == ST_CAP_DR) || (w_state == ST_SH_DR)  ||
                      (w_state == ST_EX1_DR) || (w_state == ST_PAU_DR) ||
                      (w_state == ST_EX2_DR) || (w_state == ST_UPD_DR);

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_ir_sr  <= IR_CAPTURE_VALUE;
      r_bypass <= 1'b0;
    end else begin
      if (w_state == ST_CAP_IR) r_ir_sr <= IR_CAPTURE_VALUE;
      else if (w_sh_ir)         r_ir_sr <= {TDI, r_ir_sr[IR_WIDTH-1:1]};
      if (w_state == ST_CAP_DR) r_bypass <= 1'b0;
      else if (w_sh_dr)         r_bypass <= TDI;
    end
  end

  // Unknown opcodes fall through to the bypass register
  always_comb begin
    w_sel = SEL_INT;
    if (w_sh_dr) begin
      case (r_latch_ir)
        IDCODE:                 w_sel = SEL_ID;
        USERCODE:               w_sel = SEL_USER;
        SAMPLE, EXTEST, INTEST: w_sel = SEL_BSR;
        default:                w_sel = SEL_INT;
      endcase
    end
  end

  assign w_tdo_int = w_sh_ir ? r_ir_sr[0] : r_bypass;

  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_latch_ir <= IR_RESET_VALUE;
      r_tdo_q    <= 1'b0;
      r_tdo_en   <= 1'b0;
      r_tdo_sel  <= SEL_INT;
    end else begin
      if (w_state == ST_TLR)         r_latch_ir <= IR_RESET_VALUE;
      else if (w_state == ST_UPD_IR) r_latch_ir <= r_ir_sr;
      r_tdo_q   <= w_tdo_int;
      r_tdo_en  <= w_sh_dr || w_sh_ir;
      r_tdo_sel <= w_sel;
    end
  end

  // External chains are already negedge-registered, so only the select is held here
  always_comb begin
    TDO = 1'b0;
    if (r_tdo_en) begin
      case (r_tdo_sel)
        SEL_ID:   TDO = ID_TDO;
        SEL_USER: TDO = USER_TDO;
        SEL_BSR:  TDO = BSR_TDO;
        default:  TDO = r_tdo_q;
      endcase
    end
  end

  assign LATCH_IR = r_latch_ir;
  assign TDO_EN   = r_tdo_en;
`ifdef TAP_STATE_OUT_EN
  assign TAP_STATE = w_state;
`endif

endmodule
